// File: rtl/decode_queue_if.sv
// Handshake and decoded-record bus between an instruction producer, the
// decode queue and the downstream consumer.
interface decode_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [31:0]       in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [4:0]        out_alu_op;
  logic [31:0]       out_imm;
  logic              out_write_reg;
  logic              out_write_mem;
  logic              out_mem_signed;
  logic [2:0]        out_mem_len;
  logic              out_illegal;
  logic [CNT_W-1:0]  count;

  // Producer/consumer side
  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_alu_op,
    input  out_imm, out_write_reg, out_write_mem, out_mem_signed, out_mem_len,
    input  out_illegal, count
  );

  // Queue side
  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_alu_op,
    output out_imm, out_write_reg, out_write_mem, out_mem_signed, out_mem_len,
    output out_illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I(+M) decoder feeding a DEPTH-entry FIFO of decoded records.
// Decode happens once at enqueue; the head entry is presented as-is.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter bit EN_M  = 1'b0
) (
  input logic     clk,
  input logic     rst_n,
  decode_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7,
    ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_LUI = 5'd10, ALU_AUIPC = 5'd11,
    ALU_JAL = 5'd12, ALU_JALR = 5'd13,
    ALU_BEQ = 5'd14, ALU_BNE = 5'd15, ALU_BLT = 5'd16, ALU_BGE = 5'd17,
    ALU_BLTU = 5'd18, ALU_BGEU = 5'd19,
    ALU_MUL = 5'd20, ALU_ILLEGAL = 5'd31
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        write_reg;
    logic        write_mem;
    logic        mem_signed;
    logic [2:0]  mem_len;
    logic        illegal;
  } entry_t;

  // Register-register and register-immediate ops share the funct3 mapping.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    base_op = ALU_ADD;
      3'd1:    base_op = ALU_SLL;
      3'd2:    base_op = ALU_SLT;
      3'd3:    base_op = ALU_SLTU;
      3'd4:    base_op = ALU_XOR;
      3'd5:    base_op = ALU_SRL;
      3'd6:    base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  // Access size from funct3[1:0]: byte, half, word as one-hot.
  function automatic logic [2:0] len_of(input logic [1:0] sz);
    case (sz)
      2'd0:    len_of = 3'b001;
      2'd1:    len_of = 3'b010;
      2'd2:    len_of = 3'b100;
      default: len_of = 3'b000;
    endcase
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  entry_t      dec, head, shown;
  entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic        push, pop;

  assign inst   = q.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode the incoming instruction into a queue record.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    bad = 1'b0;
    dec = '0;
    dec.pc  = q.in_pc;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    case (opcode)
      7'b0110111: begin dec.alu_op = ALU_LUI;   dec.imm = imm_u; dec.write_reg = 1'b1; end
      7'b0010111: begin dec.alu_op = ALU_AUIPC; dec.imm = imm_u; dec.write_reg = 1'b1; end
      7'b1101111: begin dec.alu_op = ALU_JAL;   dec.imm = imm_j; dec.write_reg = 1'b1; end
      7'b1100111: begin
        dec.alu_op = ALU_JALR; dec.imm = imm_i; dec.write_reg = 1'b1;
        bad = (f3 != 3'd0);
      end
      7'b1100011: begin
        dec.imm = imm_b;
        case (f3)
          3'd0:    dec.alu_op = ALU_BEQ;
          3'd1:    dec.alu_op = ALU_BNE;
          3'd4:    dec.alu_op = ALU_BLT;
          3'd5:    dec.alu_op = ALU_BGE;
          3'd6:    dec.alu_op = ALU_BLTU;
          3'd7:    dec.alu_op = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.imm = imm_i; dec.write_reg = 1'b1;
        dec.mem_len = len_of(f3[1:0]);
        dec.mem_signed = !f3[2];
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'b0100011: begin
        dec.imm = imm_s; dec.write_mem = 1'b1;
        dec.mem_len = len_of(f3[1:0]);
        bad = (f3[2] || f3[1:0] == 2'd3);
      end
      7'b0010011: begin
        dec.imm = imm_i; dec.write_reg = 1'b1;
        dec.alu_op = base_op(f3);
        if (f3 == 3'd1) begin
          bad = (f7 != 7'b0000000);
        end else if (f3 == 3'd5) begin
          if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
          else bad = (f7 != 7'b0000000);
        end
      end
      7'b0110011: begin
        dec.write_reg = 1'b1;
        case (f7)
          7'b0000000: dec.alu_op = base_op(f3);
          7'b0100000: begin
            if (f3 == 3'd0)      dec.alu_op = ALU_SUB;
            else if (f3 == 3'd5) dec.alu_op = ALU_SRA;
            else                 bad = 1'b1;
          end
          7'b0000001: begin
            if (EN_M) dec.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(f3));
            else      bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.alu_op     = ALU_ILLEGAL;
      dec.illegal    = 1'b1;
      dec.write_reg  = 1'b0;
      dec.write_mem  = 1'b0;
      dec.mem_signed = 1'b0;
      dec.mem_len    = 3'b000;
      dec.imm        = '0;
    end
  end

  assign q.out_valid = (count != '0);
  assign q.in_ready  = rst_n && (count != FULL) && !q.flush;
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; stale entries are never visible because the
    // head is masked whenever the queue is empty.
    if (push) mem[wr_ptr] <= dec;
  end

  assign head  = mem[rd_ptr];
  assign shown = q.out_valid ? head : '0;

  assign q.out_pc         = shown.pc;
  assign q.out_rs1        = shown.rs1;
  assign q.out_rs2        = shown.rs2;
  assign q.out_rd         = shown.rd;
  assign q.out_alu_op     = shown.alu_op;
  assign q.out_imm        = shown.imm;
  assign q.out_write_reg  = shown.write_reg;
  assign q.out_write_mem  = shown.write_mem;
  assign q.out_mem_signed = shown.mem_signed;
  assign q.out_mem_len    = shown.mem_len;
  assign q.out_illegal    = shown.illegal;
  assign q.count          = count;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vectors, fill/wrap ordering,
// flush and mid-traffic reset.
module tb_decode_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH)) ifm ();
  decode_queue_if #(.DEPTH(DEPTH)) ifn ();

  decode_queue #(.DEPTH(DEPTH), .EN_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .q(ifm)
  );
  decode_queue #(.DEPTH(DEPTH), .EN_M(1'b0)) dut_nom (
    .clk(clk), .rst_n(rst_n), .q(ifn)
  );

  // The RV32M-disabled instance sees the same stimulus.
  assign ifn.flush     = ifm.flush;
  assign ifn.in_valid  = ifm.in_valid;
  assign ifn.in_inst   = ifm.in_inst;
  assign ifn.in_pc     = ifm.in_pc;
  assign ifn.out_ready = ifm.out_ready;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, wm, sgn;
    logic [2:0]  len;
    logic        ill;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one vector into an empty queue, check the decoded head, pop it.
  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    ifm.in_valid = 1'b1; ifm.in_inst = v.inst; ifm.in_pc = pc; ifm.out_ready = 1'b0;
    #1;
    check("no_passthru", 32'(ifm.out_valid), 32'd0);
    tick();
    ifm.in_valid = 1'b0;
    check("valid",  32'(ifm.out_valid), 32'd1);
    check("pc",     ifm.out_pc, pc);
    check("alu_op", 32'(ifm.out_alu_op), 32'(v.alu));
    check("imm",    ifm.out_imm, v.imm);
    check("rs1",    32'(ifm.out_rs1), 32'(v.rs1));
    check("rs2",    32'(ifm.out_rs2), 32'(v.rs2));
    check("rd",     32'(ifm.out_rd), 32'(v.rd));
    check("wr_reg", 32'(ifm.out_write_reg), 32'(v.wr));
    check("wr_mem", 32'(ifm.out_write_mem), 32'(v.wm));
    check("signed", 32'(ifm.out_mem_signed), 32'(v.sgn));
    check("len",    32'(ifm.out_mem_len), 32'(v.len));
    check("illegal", 32'(ifm.out_illegal), 32'(v.ill));
    ifm.out_ready = 1'b1;
    tick();
    ifm.out_ready = 1'b0;
    check("drained", 32'(ifm.count), 32'd0);
  endtask

  // One handshake cycle checked against a reference FIFO of pcs.
  task automatic cycle(input logic vld, input logic [31:0] pc, input logic rdy);
    logic exp_rdy;
    ifm.in_valid = vld; ifm.in_inst = 32'h00000013; ifm.in_pc = pc; ifm.out_ready = rdy;
    #1;
    exp_rdy = (exp_q.size() < DEPTH);
    check("in_ready", 32'(ifm.in_ready), 32'(exp_rdy));
    tick();
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (vld && exp_rdy) exp_q.push_back(pc);
    check("count", 32'(ifm.count), 32'(exp_q.size()));
    check("out_valid", 32'(ifm.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("order_pc", ifm.out_pc, exp_q[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          inst          alu    imm            rs1    rs2    rd     wr wm sg len     ill
    vecs[0] = '{32'h00500093, 5'd0,  32'h00000005, 5'd0,  5'd5,  5'd1,  1, 0, 0, 3'b000, 0}; // addi
    vecs[1] = '{32'hFE112E23, 5'd0,  32'hFFFFFFFC, 5'd2,  5'd1,  5'd28, 0, 1, 0, 3'b100, 0}; // sw
    vecs[2] = '{32'hFF808067, 5'd13, 32'hFFFFFFF8, 5'd1,  5'd24, 5'd0,  1, 0, 0, 3'b000, 0}; // jalr
    vecs[3] = '{32'h123450B7, 5'd10, 32'h12345000, 5'd8,  5'd3,  5'd1,  1, 0, 0, 3'b000, 0}; // lui
    vecs[4] = '{32'hFE208EE3, 5'd14, 32'hFFFFFFFC, 5'd1,  5'd2,  5'd29, 0, 0, 0, 3'b000, 0}; // beq
    vecs[5] = '{32'h00334283, 5'd0,  32'h00000003, 5'd6,  5'd3,  5'd5,  1, 0, 0, 3'b001, 0}; // lbu
    vecs[6] = '{32'h00331283, 5'd0,  32'h00000003, 5'd6,  5'd3,  5'd5,  1, 0, 1, 3'b010, 0}; // lh
    vecs[7] = '{32'h4030D093, 5'd7,  32'h00000403, 5'd1,  5'd3,  5'd1,  1, 0, 0, 3'b000, 0}; // srai
    vecs[8] = '{32'h40009093, 5'd31, 32'h00000000, 5'd1,  5'd0,  5'd1,  0, 0, 0, 3'b000, 1}; // bad slli
    vecs[9] = '{32'h00000000, 5'd31, 32'h00000000, 5'd0,  5'd0,  5'd0,  0, 0, 0, 3'b000, 1}; // opcode 0

    rst_n = 1'b0;
    ifm.flush = 1'b0; ifm.in_valid = 1'b0; ifm.in_inst = '0; ifm.in_pc = '0; ifm.out_ready = 1'b0;
    tick(); tick();
    check("rst_count",   32'(ifm.count), 32'd0);
    check("rst_valid",   32'(ifm.out_valid), 32'd0);
    check("rst_ready",   32'(ifm.in_ready), 32'd0);
    check("rst_alu_op",  32'(ifm.out_alu_op), 32'd0);
    check("rst_illegal", 32'(ifm.out_illegal), 32'd0);
    check("rst_pc",      ifm.out_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(ifm.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 32'h100 + 32'(i * 4));

    // mul x3,x1,x2 with and without RV32M.
    ifm.in_valid = 1'b1; ifm.in_inst = 32'h022081B3; ifm.in_pc = 32'h180;
    tick();
    ifm.in_valid = 1'b0;
    check("mul_alu",      32'(ifm.out_alu_op), 32'd20);
    check("mul_rd",       32'(ifm.out_rd), 32'd3);
    check("mul_wr",       32'(ifm.out_write_reg), 32'd1);
    check("mul_ill",      32'(ifm.out_illegal), 32'd0);
    check("nom_alu",      32'(ifn.out_alu_op), 32'd31);
    check("nom_ill",      32'(ifn.out_illegal), 32'd1);
    check("nom_wr",       32'(ifn.out_write_reg), 32'd0);
    ifm.out_ready = 1'b1;
    tick();
    ifm.out_ready = 1'b0;

    // Fill past capacity, then stream with pointer wrap; head held while stalled.
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'h200 + 32'(k * 4), 1'b0);
    check("full_count", 32'(ifm.count), 32'd4);
    begin
      int idx = 4;
      for (int n = 0; n < 7; n++) begin
        logic acc;
        acc = (exp_q.size() < DEPTH);
        cycle(1'b1, 32'h200 + 32'(idx * 4), 1'b1);
        if (acc) idx++;
      end
    end
    for (int n = 0; n < DEPTH + 1; n++) cycle(1'b0, 32'h0, 1'b1);

    // Flush with concurrent enqueue and dequeue.
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h300 + 32'(k * 4), 1'b0);
    ifm.flush = 1'b1; ifm.in_valid = 1'b1; ifm.in_pc = 32'h3F0; ifm.out_ready = 1'b1;
    #1;
    check("flush_ready", 32'(ifm.in_ready), 32'd0);
    tick();
    ifm.flush = 1'b0; ifm.in_valid = 1'b0; ifm.out_ready = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(ifm.count), 32'd0);
    check("flush_valid", 32'(ifm.out_valid), 32'd0);
    cycle(1'b1, 32'h400, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);

    // Reset in the middle of traffic.
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h500 + 32'(k * 4), 1'b0);
    rst_n = 1'b0; ifm.in_valid = 1'b1; ifm.in_pc = 32'h5F0; ifm.out_ready = 1'b1;
    #1;
    check("mrst_ready", 32'(ifm.in_ready), 32'd0);
    tick();
    rst_n = 1'b1; ifm.in_valid = 1'b0; ifm.out_ready = 1'b0;
    exp_q.delete();
    check("mrst_count", 32'(ifm.count), 32'd0);
    check("mrst_valid", 32'(ifm.out_valid), 32'd0);
    check("mrst_pc",    ifm.out_pc, 32'd0);
    cycle(1'b1, 32'h600, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of decoded-instruction entries buffered; power of two, 2..16.
REQ-002 Parameter EN_M, default 0, 1 enables RV32M decode, 0 treats RV32M encodings as illegal.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-005 flush  input  1  discard all buffered and incoming instructions.
REQ-006 in_valid  input  1  in_inst/in_pc valid.
REQ-007 in_ready  output  1  queue accepts an instruction this cycle.
REQ-008 in_inst  input  32  raw RV32 instruction.
REQ-009 in_pc  input  32  address of in_inst.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer takes head entry this cycle.
REQ-012 out_pc  output  32  pc of head entry.
REQ-013 out_rs1, out_rs2, out_rd  output  5 each  inst[19:15], inst[24:20], inst[11:7].
REQ-014 out_alu_op  output  5  encoded op (REQ-021).
REQ-015 out_imm  output  32  sign-extended immediate per format.
REQ-016 out_write_reg, out_write_mem, out_mem_signed  output  1 each  writeback, store, signed-load flags.
REQ-017 out_mem_len  output  3  one-hot 001 byte, 010 half, 100 word, 000 non-memory.
REQ-018 out_illegal  output  1  head instruction unrecognised.
REQ-019 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-020 Decode is combinational on in_inst at enqueue; the decoded record plus pc is written into the queue; no decode at dequeue.
REQ-021 out_alu_op: 0 ADD (incl. ADDI, loads, stores), 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI, 11 AUIPC, 12 JAL, 13 JALR, 14-19 BEQ/BNE/BLT/BGE/BLTU/BGEU, 20-27 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, 31 ILLEGAL.
REQ-022 Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U = {inst[31:12],12'h000}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); R-type 0.
REQ-023 Shift-immediates: funct7 other than 0000000 (SLLI/SRLI) or 0100000 (SRAI) is illegal.
REQ-024 Illegal (unknown opcode/funct3/funct7, or RV32M with EN_M=0): out_alu_op=31, out_illegal=1, out_write_reg=0, out_write_mem=0, out_mem_len=000, out_imm=0.
REQ-025 out_write_reg=1 for R, OP-IMM, loads, LUI, AUIPC, JAL, JALR, RV32M(EN_M=1); else 0.
REQ-026 out_mem_signed=1 only for LB, LH, LW.
REQ-027 in_ready = (count < DEPTH) and not flush; no pass-through when full, even if out_ready=1.
REQ-028 Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready; both in one cycle leave count unchanged.
REQ-029 out_valid = (count != 0); out_* reflect head entry and hold stable while out_valid & !out_ready.
REQ-030 Latency: instruction accepted in cycle N is at head no earlier than cycle N+1.
REQ-031 Read/write pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-032 flush=1: next cycle count=0, pointers 0, out_valid=0; concurrent enqueue/dequeue ignored; flush has priority over all.

Reset
REQ-033 rst_n=0 at rising clk: count=0, pointers=0, out_valid=0, out_illegal=0, out_alu_op=0, all other outputs 0; reset mid-traffic discards all entries; in_ready=0 while rst_n=0.

Verification
REQ-034 Push 0x00500093 (addi x1,x0,5) pc 0x100 -> next cycle out_valid=1, alu_op=0, rd=1, rs1=0, imm=0x00000005, write_reg=1, pc=0x100.
REQ-035 Push 0xFE112E23 (sw x1,-4(x2)) -> alu_op=0, rs1=2, rs2=1, imm=0xFFFFFFFC, write_mem=1, write_reg=0, mem_len=100.
REQ-036 Push 0xFF808067 (jalr x0,-8(x1)) -> alu_op=13, imm=0xFFFFFFF8, write_reg=1; push 0x022081B3 (mul x3,x1,x2): EN_M=1 -> alu_op=20, rd=3; EN_M=0 -> alu_op=31, illegal=1, write_reg=0.
REQ-037 DEPTH=4, out_ready=0, push 5 -> count=4, in_ready=0 after 4th, 5th not accepted; then out_ready=1 with in_valid=1 -> count stays 4, order preserved across pointer wrap.
REQ-038 Queue holding 3, assert flush with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, no entry emitted or added; same with rst_n=0 instead of flush.
